bin_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle.
- Sits directly downstream of the ALU's 5-bit result bus, including the 5-by-4 divider quotient.
- Feeds the 7-segment display driver with decimal digits.
- Uses a valid/ready handshake on both sides, so the ALU result can be captured once and held for the display.

---
 rtl/ula_pkg.sv | 25 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_bcd_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and helpers for the ALU result path (binary-to-BCD conversion).
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ERR_DIGIT = 4'hE;

    // Smallest number of decimal digits able to hold 2^w-1.
    function automatic int unsigned min_digits(input int unsigned w);
        int unsigned max_val;
        int unsigned n;
        max_val = (32'd1 << w) - 32'd1;
        n = 32'd1;
        while (max_val >= 32'd10) begin
            max_val = max_val / 32'd10;
            n = n + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    assign adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Optional error passthrough (divide-by-zero shown as "E") under BIN_BCD_ERR_EN.
module bin_bcd_seq
    import ula_pkg::*;
#(
    parameter int unsigned W      = 5,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
`ifdef BIN_BCD_ERR_EN
    ,
    input  logic                  in_err,
    output logic                  out_err
`endif
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    generate
        if (W < 1 || W > 8 || DIGITS < min_digits(W)) begin : g_param_err
            $error("bin_bcd_seq: W must be 1..8 and DIGITS large enough for 2^W-1");
        end
    endgenerate

    state_t          state;
    logic [W-1:0]    bin_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcd_adj_c;
    logic [BW+W-1:0] shift_c;

    // Per-digit add-3 correction ahead of the shift.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            bcd_add3 u_add3 (
                .digit (bcd_q[4*d +: 4]),
                .adj_c (bcd_adj_c[4*d +: 4])
            );
        end
    endgenerate

    assign shift_c = {bcd_adj_c, bin_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            busy      <= 1'b0;
`ifdef BIN_BCD_ERR_EN
            out_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef BIN_BCD_ERR_EN
                        // Error results bypass conversion and show "E" on every digit.
                        if (in_err) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_bcd   <= {DIGITS{BCD_ERR_DIGIT}};
                            out_err   <= 1'b1;
                        end else
`endif
                        begin
                            state    <= SHIFT;
                            bin_q    <= in_data;
                            bcd_q    <= '0;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bin_q <= shift_c[W-1:0];
                    bcd_q <= shift_c[BW+W-1:W];
                    cnt   <= cnt + CW'(1);
                    // Publish the final accumulator directly from the last shift.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_bcd   <= shift_c[BW+W-1:W];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef BIN_BCD_ERR_EN
                        out_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq: default W=5 instance plus a W=8/DIGITS=3 sweep instance.
module tb_bin_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  in_data;
    logic [7:0]  out_bcd;
`ifdef BIN_BCD_ERR_EN
    logic        in_err, out_err;
    logic        in_err8, out_err8;
`endif

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_data8;
    logic [11:0] out_bcd8;

    bin_bcd_seq #(.W(5), .DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
        .busy(busy)
`ifdef BIN_BCD_ERR_EN
        , .in_err(in_err), .out_err(out_err)
`endif
    );

    bin_bcd_seq #(.W(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_bcd(out_bcd8),
        .busy(busy8)
`ifdef BIN_BCD_ERR_EN
        , .in_err(in_err8), .out_err(out_err8)
`endif
    );

    typedef struct {
        logic [7:0] bcd;
        logic       err;
    } exp_t;

    typedef struct {
        logic [4:0] data;
        logic [7:0] bcd;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic       hold;
    logic [7:0] hold_bcd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard consumer plus hold-stability and spurious-output checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bcd", 32'(out_bcd), 32'(hold_bcd));
            end
            if (out_valid && sb.size() == 0) begin
                fail_now("spurious_out_valid");
            end else if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("out_bcd", 32'(out_bcd), 32'(e.bcd));
`ifdef BIN_BCD_ERR_EN
                check("out_err", 32'(out_err), 32'(e.err));
`endif
            end
            hold     = out_valid && !out_ready;
            hold_bcd = out_bcd;
        end
    end

    // Offer one value; push its expectation once the handshake is certain.
    task automatic send(input logic [4:0] v, input logic err, input logic [7:0] exp);
        exp_t e;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
`ifdef BIN_BCD_ERR_EN
        in_err   = err;
`endif
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
        end else begin
            e.bcd = err ? 8'hEE : exp;
            e.err = err;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 5'($urandom);
`ifdef BIN_BCD_ERR_EN
        in_err   = 1'b0;
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        exp_t e;
        int n;

        vecs[0] = '{5'd0,  8'h00};
        vecs[1] = '{5'd10, 8'h10};
        vecs[2] = '{5'd9,  8'h09};
        vecs[3] = '{5'd31, 8'h31};
        vecs[4] = '{5'd1,  8'h01};
        vecs[5] = '{5'd19, 8'h19};
        vecs[6] = '{5'd20, 8'h20};
        vecs[7] = '{5'd15, 8'h15};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
`ifdef BIN_BCD_ERR_EN
        in_err = 1'b0; in_err8 = 1'b0;
`endif
        hold = 1'b0; hold_bcd = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: 31 accepted at edge E0, out_valid on E5, in_ready back on E6.
        in_valid = 1'b1; in_data = 5'd31;
        @(posedge clk);
        e.bcd = 8'h31; e.err = 1'b0;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        check("lat_busy_e0", 32'(busy), 32'd1);
        check("lat_ready_e0", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k < 5) begin
                check("lat_valid_early", 32'(out_valid), 32'd0);
                check("lat_busy_shift", 32'(busy), 32'd1);
            end else begin
                check("lat_valid_e5", 32'(out_valid), 32'd1);
                check("lat_busy_e5", 32'(busy), 32'd0);
                check("lat_ready_e5", 32'(in_ready), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        check("lat_ready_e6", 32'(in_ready), 32'd1);
        check("lat_valid_e6", 32'(out_valid), 32'd0);
        drain();

        // Table of back-to-back conversions.
        for (int i = 0; i < 8; i++) send(vecs[i].data, 1'b0, vecs[i].bcd);
        drain();

        // Backpressure: hold 23 for six cycles while a new request is offered.
        out_ready = 1'b0;
        send(5'd23, 1'b0, 8'h23);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("hold_wait_timeout");
        in_valid = 1'b1; in_data = 5'd4;
        repeat (6) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during the third shift cycle of 17.
        send(5'd17, 1'b0, 8'h17);
        check("rst_mid_busy", 32'(busy), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd", 32'(out_bcd), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(5'd5, 1'b0, 8'h05);
        drain();

`ifdef BIN_BCD_ERR_EN
        // Error input skips conversion and shows EE for one-edge latency.
        in_valid = 1'b1; in_data = 5'd7; in_err = 1'b1;
        @(posedge clk);
        e.bcd = 8'hEE; e.err = 1'b1;
        sb.push_back(e);
        #1;
        in_valid = 1'b0; in_err = 1'b0;
        check("err_valid_e1", 32'(out_valid), 32'd1);
        check("err_flag_e1", 32'(out_err), 32'd1);
        check("err_bcd_e1", 32'(out_bcd), 32'hEE);
        drain();
        send(5'd12, 1'b0, 8'h12);
        drain();
`endif

        // Full sweep at W=5.
        for (int v = 0; v < 32; v++) begin
            logic [11:0] r;
            r = ref_bcd(v);
            send(5'(v), 1'b0, r[7:0]);
        end
        drain();

        // Full sweep at W=8, DIGITS=3.
        for (int v = 0; v < 256; v++) begin
            logic [11:0] r;
            r = ref_bcd(v);
            in_valid8 = 1'b1;
            in_data8  = 8'(v);
            n = 0;
            forever begin
                @(negedge clk);
                if (in_ready8 || n > 50) break;
                n++;
            end
            if (!in_ready8) fail_now("w8_accept_timeout");
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            n = 0;
            forever begin
                @(negedge clk);
                if (out_valid8 || n > 50) break;
                n++;
            end
            if (!out_valid8) fail_now("w8_result_timeout");
            else check("w8_out_bcd", 32'(out_bcd8), 32'(r));
        end
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
